// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle unsigned restoring divider. It divides a DW-bit dividend by a
// VW-bit divisor and produces one quotient bit per clock. A request is taken on
// `start` while idle. Completion is marked by a single-cycle `done` pulse,
// which appears DW clocks after the start edge.
//
// Optional feature: when the macro SEQ_DIVIDER_DIV_ZERO_EN is defined, a zero
// divisor takes a one-cycle fast path. That path returns quotient = all ones,
// remainder = 0 and div_by_zero = 1. When the macro is not defined, a zero
// divisor runs the normal iterations and div_by_zero is always 0.
//
// Parameters
//   DW           dividend / quotient width, and also the iteration count
//   VW           divisor / remainder width
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only while busy = 0
//   dividend     unsigned dividend, captured when start is accepted
//   divisor      unsigned divisor, captured when start is accepted
//   busy         high while iterating
//   done         single-cycle pulse; results valid
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   div_by_zero  divisor was 0 (fast-path build only); updates with done
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // dvd holds the dividend bits that have not been consumed yet. Quotient bits
  // are shifted in at the LSB end, so after DW steps it holds the quotient.
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  // The working remainder is one bit wider than the divisor. This keeps the
  // shifted value (at most 2*divisor-1) from overflowing before the compare.
  logic [VW:0]   rem_q, rem_d;
  logic          dz_pend_q, dz_pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          div_by_zero_q, div_by_zero_d;

  // One restoring step.
  logic [VW:0]   rem_shift;
  logic [VW:0]   rem_sub;
  logic          q_bit;
  logic [VW:0]   rem_next;
  logic [DW-1:0] dvd_next;

  always_comb begin
    rem_shift = {rem_q[VW-1:0], dvd_q[DW-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_next  = q_bit ? rem_sub : rem_shift;
    dvd_next  = {dvd_q[DW-2:0], q_bit};
  end

  always_comb begin
    // NOTE: every signal gets a default here. A path that left one unassigned
    // would infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    rem_d         = rem_q;
    dz_pend_d     = dz_pend_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d     = dividend;
          dvs_d     = divisor;
          rem_d     = '0;
          cnt_d     = CW'(DW);
          dz_pend_d = DZ_EN && (divisor == '0);
          busy_d    = 1'b1;
          state_d   = CALC;
        end
      end

      CALC: begin
        if (dz_pend_q) begin
          quotient_d    = '1;
          remainder_d   = '0;
          div_by_zero_d = 1'b1;
          dz_pend_d     = 1'b0;
          done_d        = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          rem_d = rem_next;
          dvd_d = dvd_next;
          cnt_d = cnt_q - CW'(1);
          // This is the last step, the one that takes the counter to zero.
          // The results come straight from this step, so done follows E_DW.
          if (cnt_q == CW'(1)) begin
            quotient_d    = dvd_next;
            remainder_d   = rem_next[VW-1:0];
            div_by_zero_d = 1'b0;
            done_d        = 1'b1;
            busy_d        = 1'b0;
            state_d       = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Each flop then
  // samples the pre-edge values of the others, which gives order-independent
  // simulation that matches the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      dz_pend_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      rem_q         <= rem_d;
      dz_pend_q     <= dz_pend_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed testbench for seq_divider using the default parameters (DW=8, VW=4).
// Each scenario lives in its own task and makes its own comparisons. The
// expected values in the divide-by-zero case depend on whether
// SEQ_DIVIDER_DIV_ZERO_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.DW(8), .VW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse start for one edge, then wait (bounded) for done.
  // lat      = number of edges after the start edge up to the done sample.
  // busy_cnt = number of samples, from the start edge on, where busy was high.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         output int lat, output int busy_cnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      busy_cnt += (busy === 1'b1) ? 1 : 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (quotient !== 8'd0) begin n_fail++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
    n_checks++; if (remainder !== 4'd0) begin n_fail++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc;
    run_div(8'd6, 4'd2, lat, bc);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    n_checks++; if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    n_checks++; if (quotient !== 8'd3) begin n_fail++; $display("FAIL basic_quotient: got %0d expected 3", quotient); end
    n_checks++; if (remainder !== 4'd0) begin n_fail++; $display("FAIL basic_remainder: got %0d expected 0", remainder); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (quotient !== 8'd3) begin n_fail++; $display("FAIL basic_hold_quotient: got %0d expected 3", quotient); end
  endtask

  task automatic test_extremes();
    logic [7:0] a_tab [4] = '{8'd200, 8'd255, 8'd5, 8'd255};
    logic [3:0] b_tab [4] = '{4'd7,   4'd15,  4'd9, 4'd1};
    logic [7:0] q_tab [4] = '{8'd28,  8'd17,  8'd0, 8'd255};
    logic [3:0] r_tab [4] = '{4'd4,   4'd0,   4'd5, 4'd0};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_div(a_tab[i], b_tab[i], lat, bc);
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL extreme%0d_latency: got %0d expected 8", i, lat); end
      n_checks++; if (quotient !== q_tab[i]) begin n_fail++; $display("FAIL extreme%0d_quotient: got %0d expected %0d", i, quotient, q_tab[i]); end
      n_checks++; if (remainder !== r_tab[i]) begin n_fail++; $display("FAIL extreme%0d_remainder: got %0d expected %0d", i, remainder, r_tab[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    dividend = 8'd100; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 2) begin start = 1'b1; dividend = 8'd50; divisor = 4'd5; end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
    n_checks++; if (quotient !== 8'd33) begin n_fail++; $display("FAIL ignore_quotient: got %0d expected 33", quotient); end
    n_checks++; if (remainder !== 4'd1) begin n_fail++; $display("FAIL ignore_remainder: got %0d expected 1", remainder); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queued_op: busy got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_div(8'd100, 4'd3, lat, bc);
    n_checks++; if (quotient !== 8'd33) begin n_fail++; $display("FAIL b2b_first_quotient: got %0d expected 33", quotient); end
    // start goes out while done is high
    run_div(8'd9, 4'd4, lat, bc);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    n_checks++; if (quotient !== 8'd2) begin n_fail++; $display("FAIL b2b_quotient: got %0d expected 2", quotient); end
    n_checks++; if (remainder !== 4'd1) begin n_fail++; $display("FAIL b2b_remainder: got %0d expected 1", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    bit seen_done;
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done); end
    n_checks++; if (quotient !== 8'd0) begin n_fail++; $display("FAIL rstmid_quotient: got %0d expected 0", quotient); end
    n_checks++; if (remainder !== 4'd0) begin n_fail++; $display("FAIL rstmid_remainder: got %0d expected 0", remainder); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_abandoned: activity got %b expected 0", seen_done); end
    run_div(8'd6, 4'd2, lat, bc);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL rstmid_new_latency: got %0d expected 8", lat); end
    n_checks++; if (quotient !== 8'd3) begin n_fail++; $display("FAIL rstmid_new_quotient: got %0d expected 3", quotient); end
    n_checks++; if (remainder !== 4'd0) begin n_fail++; $display("FAIL rstmid_new_remainder: got %0d expected 0", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat, bc;
    int exp_lat;
    logic [3:0] exp_r;
    logic exp_dz;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    exp_lat = 1; exp_r = 4'd0; exp_dz = 1'b1;
`else
    exp_lat = 8; exp_r = 4'hD; exp_dz = 1'b0;
`endif
    run_div(8'd13, 4'd0, lat, bc);
    n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL dz_latency: got %0d expected %0d", lat, exp_lat); end
    n_checks++; if (quotient !== 8'hFF) begin n_fail++; $display("FAIL dz_quotient: got %0h expected ff", quotient); end
    n_checks++; if (remainder !== exp_r) begin n_fail++; $display("FAIL dz_remainder: got %0h expected %0h", remainder, exp_r); end
    n_checks++; if (div_by_zero !== exp_dz) begin n_fail++; $display("FAIL dz_flag: got %b expected %b", div_by_zero, exp_dz); end
    // a nonzero divisor afterwards must clear the flag
    run_div(8'd10, 4'd3, lat, bc);
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_flag_clear: got %b expected 0", div_by_zero); end
    n_checks++; if (quotient !== 8'd3) begin n_fail++; $display("FAIL dz_after_quotient: got %0d expected 3", quotient); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat, bc;
    int shown = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(a[7:0], b[3:0], lat, bc);
        n_checks++;
        if ((int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b) begin
          n_fail++;
          if (shown < 10) $display("FAIL sweep_%0d_div_%0d: got q=%0d r=%0d expected q=%0d r=%0d", a, b, quotient, remainder, a / b, a % b);
          shown++;
        end
        n_checks++;
        if (lat != 8 || bc != 8) begin
          n_fail++;
          if (shown < 10) $display("FAIL sweep_%0d_div_%0d_protocol: got latency=%0d busy=%0d expected 8/8", a, b, lat, bc);
          shown++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_div_zero();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider. It is the inverse companion to the team's combinational multiplier: it takes an 8-bit dividend and a 4-bit divisor and returns the quotient and remainder. Computation starts on a `start`/`busy`/`done` handshake and produces one quotient bit per clock. A multiply→divide round-trip check in the lab top level uses it.

## Interface
- `DW`, 8, dividend and quotient width (bits); also the iteration count
- `VW`, 4, divisor and remainder width (bits)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only when `busy`=0
- `dividend`  in  DW  unsigned dividend; captured on accepted `start`
- `divisor`  in  VW  unsigned divisor; captured on accepted `start`
- `busy`  out  1  high while iterating
- `done`  out  1  single-cycle pulse; results valid
- `quotient`  out  DW  result; held until next completion
- `remainder`  out  VW  result; held until next completion
- `div_by_zero`  out  1  divisor was 0 (see Configuration); updates with `done`

## Operation
- FSM states: IDLE, CALC.
  - IDLE + `start` → capture operands, clear the working remainder (VW+1 bits), load counter = DW, go to CALC.
  - CALC → each cycle:
    - shift the working remainder left and shift in the dividend MSB;
    - if remainder ≥ divisor, subtract the divisor and shift 1 into the quotient LSB; otherwise restore and shift 0;
    - decrement the counter.
  - CALC, counter reaches 0 → register `quotient`/`remainder`, pulse `done`, return to IDLE.
- Working remainder is VW+1 bits so the compare never overflows. The final remainder is truncated to VW bits, which is always exact for a nonzero divisor.
- `start` while `busy`=1 is ignored. Operands are not re-sampled.
- `start` in the same cycle `done`=1 (FSM already in IDLE) is accepted. Back-to-back divisions run with no dead cycle.
- Output registers change only at completion. Between completions they hold their last value.
- Reset (any time, including mid-CALC): state IDLE, and all outputs go to 0 (`busy`, `done`, `quotient`, `remainder`, `div_by_zero`). An in-flight operation is abandoned with no `done`.

## Timing
- `start` is sampled high at edge E0 (FSM in IDLE).
- `busy`=1 after E0. Iterations run on E1..E_DW.
- After E_DW: `busy`=0, `done`=1, results valid. `done` falls at E_DW+1.
- Latency is DW clocks (8 by default), start edge to `done`. Throughput is one result per DW clocks.
- Divide-by-zero fast path (macro enabled): completes after E1, so `done`=1 one clock after the start edge.
- No combinational path from inputs to outputs.

## Configuration
- `SEQ_DIVIDER_DIV_ZERO_EN` defined:
  - divisor==0 at an accepted `start` skips CALC;
  - `quotient`=all ones, `remainder`=0, `div_by_zero`=1, `done` pulses one clock after the start edge.
  - `div_by_zero` is 0 for every nonzero divisor.
- Not defined:
  - `div_by_zero` is tied to 0 and there is no special path;
  - divisor 0 runs the full DW iterations and naturally yields `quotient`=all ones, `remainder`=`dividend[VW-1:0]`.

## Test plan
- Basic: 6 ÷ 2 with `start` pulse → `done` 8 clocks later, `quotient`=3, `remainder`=0, `busy` high for exactly 8 cycles.
- Nontrivial remainder and width extremes:
  - 200 ÷ 7 → q=28, r=4;
  - 255 ÷ 15 → q=17, r=0;
  - 5 ÷ 9 → q=0, r=5;
  - 255 ÷ 1 → q=255, r=0.
- Handshake:
  - `start` with 100 ÷ 3 re-pulsed at cycle 3 with 50 ÷ 5 → the second request is ignored and the result is q=33, r=1;
  - `start` asserted during the `done` cycle with 9 ÷ 4 → next `done` exactly 8 clocks later, q=2, r=1.
- Reset mid-operation: `rst_n` low at cycle 4 of 200 ÷ 7 → all outputs 0 immediately, no `done`; new 6 ÷ 2 afterwards → q=3, r=0.
- Divide by zero, 13 ÷ 0:
  - with the macro defined → `done` 1 clock after start, q=0xFF, r=0, `div_by_zero`=1;
  - without it → `done` after 8 clocks, q=0xFF, r=0xD, `div_by_zero`=0.
- Exhaustive sweep: all dividend 0..255 × divisor 1..15 → q×divisor + r == dividend and r < divisor, with no protocol violations.
